// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// RV32I load/store unit in the execute/memory stage. Takes the ALU result as
// the effective address and rs2 as store data. Runs one request/grant/response
// transaction on the data-memory port per memory instruction, and stalls the
// core while that transaction is in flight.
//
// Ports
//   clk, rst_n      core clock (rising edge), asynchronous active-low reset
//   start           memory instruction present; held by the core until done
//   is_load         LB/LH/LW/LBU/LHU
//   is_store        SB/SH/SW
//   funct3          width/sign field of the instruction
//   addr            effective address
//   store_data      rs2 value
//   stall           start && not in the completion cycle (combinational)
//   done            one-cycle completion pulse
//   error           valid with done: misaligned/illegal access, no bus traffic
//   load_data       aligned and extended load result, held until next load
//   mem_req         registered request, held until mem_gnt
//   mem_we          1 = write
//   mem_addr        word-aligned address
//   mem_be          byte enables
//   mem_wdata       lane-replicated write data
//   mem_gnt         request accepted this cycle (only looked at in REQ)
//   mem_rvalid      read data valid (only looked at in WAIT)
//   mem_rdata       read word
// -----------------------------------------------------------------------------
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic        error,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // An access is legal when it is exactly one of load/store, uses a funct3
  // that exists for that direction, and is naturally aligned for its size.
  function automatic logic f_access_legal(
    input logic       ld,
    input logic       st,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic f3_ok;
    logic aligned;
    case (f3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ld;
      default:                f3_ok = 1'b0;
    endcase
    case (f3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~off[0];
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b0;
    endcase
    return (ld != st) && f3_ok && aligned;
  endfunction

  // Byte enables for the accessed lanes; size is funct3[1:0].
  function automatic logic [3:0] f_byte_enable(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the store value across all lanes so that whichever lanes the
  // byte enables select carry the right data without a barrel shifter.
  function automatic logic [31:0] f_lane_data(
    input logic [1:0]  size,
    input logic [31:0] data
  );
    logic [31:0] wd;
    case (size)
      2'b00:   wd = {4{data[7:0]}};
      2'b01:   wd = {2{data[15:0]}};
      2'b10:   wd = data;
      default: wd = 32'd0;
    endcase
    return wd;
  endfunction

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [31:0] f_extract_load(
    input logic [2:0]  f3,
    input logic [1:0]  off,
    input logic [31:0] rdata
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      2'd3:    b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
    // Halfword legality guarantees off[0]==0, so only off[1] selects.
    if (off[1]) begin
      h = rdata[31:16];
    end else begin
      h = rdata[15:0];
    end
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b010:  res = rdata;
      3'b100:  res = {24'd0, b};
      3'b101:  res = {16'd0, h};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t      r_state;
  logic        r_is_load;
  logic [2:0]  r_funct3;
  logic [1:0]  r_offset;
  logic        r_done;
  logic        r_error;
  logic [31:0] r_load_data;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;

  logic        w_legal;

  // Legality of the instruction currently presented by the core.
  always_comb begin
    w_legal = f_access_legal(is_load, is_store, funct3, addr[1:0]);
  end

  // Stall drops in the completion cycle so the core can advance.
  always_comb begin
    stall = start && (r_state != ST_DONE);
  end

  // Transaction FSM with registered bus and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_is_load   <= 1'b0;
      r_funct3    <= 3'd0;
      r_offset    <= 2'd0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_load_data <= 32'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_be    <= 4'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      // done/error are single-cycle; only the transition into DONE sets them.
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_is_load <= is_load;
            r_funct3  <= funct3;
            r_offset  <= addr[1:0];
            if (!w_legal) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end else begin
              r_state     <= ST_REQ;
              r_mem_req   <= 1'b1;
              r_mem_we    <= is_store;
              r_mem_addr  <= {addr[31:2], 2'b00};
              r_mem_be    <= f_byte_enable(funct3[1:0], addr[1:0]);
              r_mem_wdata <= f_lane_data(funct3[1:0], store_data);
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            if (r_is_load) begin
              r_state <= ST_WAIT;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_state <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            r_load_data <= f_extract_load(r_funct3, r_offset, mem_rdata);
            r_state     <= ST_DONE;
            r_done      <= 1'b1;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_DONE: begin
          // Always pass through IDLE, even if start is still high.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign done      = r_done;
  assign error     = r_error;
  assign load_data = r_load_data;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, done, error;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_load;

  // results of the most recent run_txn
  int          dc, rc, rf, bu, sb;
  logic        e, cwe;
  logic [31:0] ldo, cad, cwd;
  logic [3:0]  cbe;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall), .done(done),
    .error(error), .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // ---------------- reference model (RV32I semantics) ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a);
    if (ld == st) return 1'b0;
    if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
    return (a % m_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be;
    int off;
    be = 4'd0;
    off = int'(a % 4);
    for (int i = 0; i < m_size(f3); i++) be[off + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % m_size(f3)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v, mask;
    int sz;
    sz = m_size(f3);
    v = rd >> (8 * (a % 4));
    if (sz < 4) begin
      mask = (32'd1 << (8 * sz)) - 32'd1;
      v = v & mask;
      if (f3[2] == 1'b0 && v[8*sz-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic int m_done_cycle(input bit ld, input bit err, input int gd, input int rd);
    if (err) return 1;
    if (ld) return 3 + gd + rd;
    return 2 + gd;
  endfunction

  // ---------------- transaction driver (no checking) ----------------
  // Cycle 0 = cycle where start is presented in IDLE. gnt is given in cycle
  // 1+gd, rvalid in cycle 2+gd+rd. With spur, rvalid pulses with junk data
  // while still in REQ and gnt stays high after the real grant.
  task automatic run_txn(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input int gd, input int rd, input logic [31:0] rdat, input bit spur);
    dc = -1; rc = 0; rf = -1; bu = 0; sb = 0; e = 1'bx; ldo = 32'hx;
    cwe = 1'bx; cad = 32'hx; cbe = 4'hx; cwd = 32'hx;
    @(negedge clk);
    start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
    #1;
    if (stall !== 1'b1) sb++;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (rc == 0) begin
          rf = c; cwe = mem_we; cad = mem_addr; cbe = mem_be; cwd = mem_wdata;
        end else if (cwe !== mem_we || cad !== mem_addr || cbe !== mem_be || cwd !== mem_wdata) begin
          bu++;
        end
        rc++;
      end else if (mem_req !== 1'b0) begin
        rc += 100;
      end
      if (done === 1'b1) begin
        dc = c; e = error; ldo = load_data;
        if (stall !== 1'b0) sb++;
        start = 1'b0; is_load = 1'b0; is_store = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        break;
      end
      if (stall !== 1'b1) sb++;
      mem_gnt = (c == 1 + gd) || (spur && c > 1 + gd);
      if (c == 2 + gd + rd) begin
        mem_rvalid = 1'b1; mem_rdata = rdat;
      end else if (spur && c <= gd) begin
        mem_rvalid = 1'b1; mem_rdata = ~rdat;
      end else begin
        mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
    end
    if (dc < 0) begin
      start = 1'b0; is_load = 1'b0; is_store = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = 32'd0; store_data = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    #12;
    checks++;
    if ({mem_req, mem_we, done, error, stall} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, done, error, stall});
    end
    checks++;
    if (mem_be !== 4'd0 || mem_addr !== 32'd0) begin
      failures++; $display("FAIL reset_be_addr: got be=%h addr=%h expected 0", mem_be, mem_addr);
    end
    checks++;
    if (mem_wdata !== 32'd0 || load_data !== 32'd0) begin
      failures++; $display("FAIL reset_data: got wdata=%h load_data=%h expected 0", mem_wdata, load_data);
    end
    last_load = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stores;
    run_txn(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'd0, 1'b0);
    checks++;
    if (dc !== 2 || e !== 1'b0 || rf !== 1 || rc !== 1) begin
      failures++; $display("FAIL sw_timing: got done=%0d err=%b req_first=%0d req_cycles=%0d expected 2 0 1 1", dc, e, rf, rc);
    end
    checks++;
    if (cwe !== 1'b1 || cad !== 32'h100 || cbe !== 4'b1111 || cwd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL sw_bus: got we=%b addr=%h be=%b wdata=%h expected 1 100 1111 deadbeef", cwe, cad, cbe, cwd);
    end
    run_txn(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 1, 0, 32'd0, 1'b1);
    checks++;
    if (dc !== 3 || cad !== 32'h100 || cbe !== 4'b1000 || cwd !== 32'hA5A5A5A5 || bu !== 0) begin
      failures++; $display("FAIL sb_bus: got done=%0d addr=%h be=%b wdata=%h unstable=%0d expected 3 100 1000 a5a5a5a5 0", dc, cad, cbe, cwd, bu);
    end
    run_txn(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234CAFE, 0, 0, 32'd0, 1'b0);
    checks++;
    if (dc !== 2 || cbe !== 4'b1100 || cwd !== 32'hCAFECAFE) begin
      failures++; $display("FAIL sh_bus: got done=%0d be=%b wdata=%h expected 2 1100 cafecafe", dc, cbe, cwd);
    end
  endtask

  task automatic test_loads;
    run_txn(1'b1, 1'b0, 3'b000, 32'h201, 32'd0, 2, 2, 32'h00008000, 1'b1);
    checks++;
    if (dc !== 7 || ldo !== 32'hFFFFFF80 || cwe !== 1'b0 || cbe !== 4'b0010) begin
      failures++; $display("FAIL lb: got done=%0d data=%h we=%b be=%b expected 7 ffffff80 0 0010", dc, ldo, cwe, cbe);
    end
    checks++;
    if (sb !== 0 || rc !== 3 || bu !== 0) begin
      failures++; $display("FAIL lb_stall_req: got stall_bad=%0d req_cycles=%0d unstable=%0d expected 0 3 0", sb, rc, bu);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL lb_done_once: got done=%b expected 0", done);
    end
    run_txn(1'b1, 1'b0, 3'b101, 32'h202, 32'd0, 0, 0, 32'h80010000, 1'b0);
    checks++;
    if (dc !== 3 || ldo !== 32'h00008001) begin
      failures++; $display("FAIL lhu: got done=%0d data=%h expected 3 00008001", dc, ldo);
    end
    run_txn(1'b1, 1'b0, 3'b001, 32'h202, 32'd0, 0, 1, 32'h80010000, 1'b0);
    checks++;
    if (dc !== 4 || ldo !== 32'hFFFF8001) begin
      failures++; $display("FAIL lh: got done=%0d data=%h expected 4 ffff8001", dc, ldo);
    end
    last_load = 32'hFFFF8001;
  endtask

  task automatic test_errors;
    logic [38:0] cases [4];
    // {ld, st, funct3, addr}
    cases[0] = {1'b1, 1'b0, 3'b010, 32'h102};
    cases[1] = {1'b0, 1'b1, 3'b001, 32'h101};
    cases[2] = {1'b1, 1'b0, 3'b011, 32'h100};
    cases[3] = {1'b1, 1'b1, 3'b000, 32'h100};
    for (int i = 0; i < 4; i++) begin
      run_txn(cases[i][38], cases[i][37], cases[i][36:34], cases[i][31:0], 32'h55AA55AA, 0, 0, 32'd0, 1'b1);
      checks++;
      if (dc !== 1 || e !== 1'b1 || rc !== 0 || sb !== 0 || ldo !== last_load) begin
        failures++; $display("FAIL error_%0d: got done=%0d err=%b req_cycles=%0d stall_bad=%0d data=%h expected 1 1 0 0 %h",
                             i, dc, e, rc, sb, ldo, last_load);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b0, 1'b1, 3'b010, 32'h40 + 32'(4 * i), 32'h1000 + 32'(i), 0, 0, 32'd0, 1'b0);
      checks++;
      if (dc !== 2 || cad !== 32'h40 + 32'(4 * i) || cwd !== 32'h1000 + 32'(i) || ldo !== last_load) begin
        failures++; $display("FAIL b2b_%0d: got done=%0d addr=%h wdata=%h data=%h expected 2 %h %h %h",
                             i, dc, cad, cwd, ldo, 32'h40 + 32'(4 * i), 32'h1000 + 32'(i), last_load);
      end
    end
  endtask

  task automatic test_reset_in_flight;
    // reset during REQ drops the request asynchronously
    @(negedge clk);
    start = 1'b1; is_load = 1'b0; is_store = 1'b1; funct3 = 3'b010; addr = 32'h500; store_data = 32'h1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++; $display("FAIL rst_in_req: got mem_req=%b expected 0", mem_req);
    end
    start = 1'b0; is_store = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    // reset during WAIT
    @(negedge clk);
    start = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h300; mem_gnt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    start = 1'b0; is_load = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || done !== 1'b0 || load_data !== 32'd0) begin
      failures++; $display("FAIL rst_in_wait: got req=%b done=%b data=%h expected 0 0 0", mem_req, done, load_data);
    end
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || load_data !== 32'd0 || mem_req !== 1'b0) begin
        failures++; $display("FAIL rst_late_rvalid: got done=%b data=%h req=%b expected 0 0 0", done, load_data, mem_req);
      end
    end
    mem_rvalid = 1'b0;
    last_load = 32'd0;
    run_txn(1'b0, 1'b1, 3'b010, 32'h400, 32'h0BADF00D, 0, 0, 32'd0, 1'b0);
    checks++;
    if (dc !== 2 || e !== 1'b0 || cad !== 32'h400 || cwd !== 32'h0BADF00D || cbe !== 4'b1111) begin
      failures++; $display("FAIL rst_then_sw: got done=%0d err=%b addr=%h wdata=%h be=%b expected 2 0 400 0badf00d 1111",
                           dc, e, cad, cwd, cbe);
    end
  endtask

  task automatic test_random;
    bit ld, st, err, spur;
    logic [2:0] f3;
    logic [31:0] a, sd, rdat, exp_ld;
    int gd, rd, sel, exp_dc;
    logic [2:0] legal_f3 [5];
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2; legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin ld = 1'b1; st = 1'b1; end
      else if (sel == 1) begin ld = 1'b0; st = 1'b0; end
      else begin ld = sel[0]; st = !sel[0]; end
      if ($urandom_range(0, 3) != 0) f3 = legal_f3[$urandom_range(0, ld ? 4 : 2)];
      else f3 = 3'($urandom_range(0, 7));
      a = $urandom; sd = $urandom; rdat = $urandom;
      gd = $urandom_range(0, 3); rd = $urandom_range(0, 3); spur = 1'($urandom_range(0, 1));
      err = !m_legal(ld, st, f3, a);
      exp_dc = m_done_cycle(ld, err, gd, rd);
      run_txn(ld, st, f3, a, sd, gd, rd, rdat, spur);
      exp_ld = (ld && !err) ? m_load(f3, a, rdat) : last_load;
      checks++;
      if (dc !== exp_dc || e !== err || sb !== 0 || bu !== 0) begin
        failures++; $display("FAIL rnd_%0d_ctrl: got done=%0d err=%b stall_bad=%0d unstable=%0d expected %0d %b 0 0",
                             n, dc, e, sb, bu, exp_dc, err);
      end
      checks++;
      if (rc !== (err ? 0 : gd + 1)) begin
        failures++; $display("FAIL rnd_%0d_req: got req_cycles=%0d expected %0d", n, rc, err ? 0 : gd + 1);
      end
      if (!err) begin
        checks++;
        if (cwe !== st || cad !== {a[31:2], 2'b00} || cbe !== m_be(f3, a) || (st && cwd !== m_wdata(f3, sd))) begin
          failures++; $display("FAIL rnd_%0d_bus: got we=%b addr=%h be=%b wdata=%h expected %b %h %b %h",
                               n, cwe, cad, cbe, cwd, st, {a[31:2], 2'b00}, m_be(f3, a), m_wdata(f3, sd));
        end
      end
      checks++;
      if (ldo !== exp_ld) begin
        failures++; $display("FAIL rnd_%0d_load: got %h expected %h (f3=%b addr=%h rdata=%h)", n, ldo, exp_ld, f3, a, rdat);
      end
      last_load = exp_ld;
    end
  endtask

  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_errors();
    test_back_to_back();
    test_reset_in_flight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit in the execute/memory stage of the RV32I core, directly downstream of the ALU. It takes the ALU result as the effective address and rs2 as store data, and runs one request/grant/response transaction on the data-memory port. It generates byte enables and lane-replicated write data, and aligns and sign/zero-extends load data. While an access is in flight it stalls the core.

## Interface
Parameters: none (RV32, 32-bit data/address fixed).

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  memory instruction present in this stage; held high by the core until done
- is_load  in  1  instruction is LB/LH/LW/LBU/LHU
- is_store  in  1  instruction is SB/SH/SW
- funct3  in  3  width/sign field from the instruction
- addr  in  32  effective address (ALU result)
- store_data  in  32  rs2 value
- stall  out  1  combinational: start && state!=DONE
- done  out  1  one-cycle pulse, access complete (state DONE)
- error  out  1  valid with done: misaligned or illegal access, no memory traffic issued
- load_data  out  32  aligned and extended load result, valid with done (load, !error)
- mem_req  out  1  registered request
- mem_we  out  1  1 = write
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  write data, lanes replicated
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid, arrives at least 1 cycle after gnt
- mem_rdata  in  32  read word

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on start=1, latch addr, funct3, is_load, store_data.
  - Error if is_load==is_store, if funct3 is not legal (load: 000,001,010,100,101; store: 000,001,010), or if the access is misaligned (half with addr[0]=1, word with addr[1:0]!=0). On error, go to DONE with error=1.
  - Otherwise go to REQ.
- REQ: mem_req=1 with stable mem_we/addr/be/wdata until mem_gnt.
  - On gnt, a store goes to DONE and a load goes to WAIT.
- WAIT: on mem_rvalid, register the extracted data into load_data and go to DONE.
- DONE: done=1, stall=0. Always return to IDLE; no restart from DONE even if start is still high.
- Byte enables:
  - byte: 0001<<addr[1:0]
  - half: 0011<<addr[1:0]
  - word: 1111
- Write data:
  - SB: {4{rs2[7:0]}}
  - SH: {2{rs2[15:0]}}
  - SW: rs2
- Load extraction: select the byte at addr[1:0] or the half at addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- mem_rvalid outside WAIT and mem_gnt outside REQ are ignored.
- Reset (any state, asynchronous):
  - state=IDLE
  - mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0
  - load_data=0, done=0, error=0
  - An in-flight transaction is abandoned.

## Timing
- Start seen in IDLE at cycle N:
  - mem_req=1 from N+1.
  - Zero-wait store: gnt at N+1, done at N+2.
  - Zero-wait load: gnt at N+1, rvalid at N+2, done and load_data at N+3.
- Each cycle without gnt adds 1 cycle in REQ. Each cycle without rvalid adds 1 cycle in WAIT.
- Error path: done=1 and error=1 at N+1. mem_req is never asserted.
- stall is high from cycle N through the cycle before done. It is low in the done cycle.
- Back-to-back: a new start is accepted in the cycle after DONE (IDLE), giving a minimum of 3 cycles per store.
- load_data holds its value until the next completed load.

## Test plan
- SW: addr=0x100, rs2=0xDEADBEEF, gnt immediate.
  - Expect mem_addr=0x100, be=1111, wdata=0xDEADBEEF, we=1, done at N+2.
- SB: addr=0x103, rs2=0x000000A5.
  - Expect be=1000, wdata=0xA5A5A5A5.
- SH: addr=0x102.
  - Expect be=1100.
- LB: addr=0x201, rdata=0x0000_8000, gnt delayed 2 cycles, rvalid 3 cycles after gnt.
  - Expect load_data=0xFFFFFF80.
  - Stall stays high for the whole transaction; done occurs exactly once.
- LHU: addr=0x202, rdata=0x8001_0000.
  - Expect load_data=0x00008001.
- LH: addr=0x202, same rdata.
  - Expect load_data=0xFFFF8001.
- Misaligned LW at 0x102 and SH at 0x101.
  - Expect error=1 with done at N+1 and mem_req never high.
- Illegal funct3=011, and is_load=is_store=1.
  - Expect the same error response as the misaligned case.
- Reset in WAIT.
  - Expect mem_req=0 and state IDLE immediately; a later rvalid is ignored.
  - Expect a new SW to complete normally afterwards.
